// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets NREQ requesters set or clear a bank of NFLAG
// SR flag latches, one IDLE -> DRIVE -> ACK transaction at a time.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req,
    input  logic [NREQ-1:0]                  op,
    input  logic [NREQ*$clog2(NFLAG)-1:0]    idx,
    output logic [NREQ-1:0]                  ack,
    output logic [NFLAG-1:0]                 s_out,
    output logic [NFLAG-1:0]                 r_out,
    output logic [NFLAG-1:0]                 e_out,
    output logic [NFLAG-1:0]                 flags,
    output logic                             busy
);

    localparam int IW = $clog2(NFLAG);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;

    logic             found;
    logic [PW-1:0]    win_nxt;
    logic [PW:0]      cand;
    logic             op_nxt;
    logic [IW-1:0]    idx_nxt;
    logic [NFLAG-1:0] dec_nxt;

    // Search upward from ptr with wrap; the first requester found wins.
    always_comb begin
        found   = 1'b0;
        win_nxt = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!found && req[cand[PW-1:0]]) begin
                found   = 1'b1;
                win_nxt = cand[PW-1:0];
            end
        end
        op_nxt  = op[win_nxt];
        idx_nxt = idx[win_nxt*IW +: IW];
        dec_nxt = {{(NFLAG-1){1'b0}}, 1'b1} << idx_nxt;
    end

    // Strobes and the shadow flag are registered at the grant edge, so they
    // appear during the DRIVE cycle and carry the op/idx sampled at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            flags <= '0;
            ack   <= '0;
            s_out <= '0;
            r_out <= '0;
            e_out <= '0;
            busy  <= 1'b0;
        end else begin
            ack   <= '0;
            s_out <= '0;
            r_out <= '0;
            e_out <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        e_out          <= dec_nxt;
                        s_out          <= op_nxt ? dec_nxt : '0;
                        r_out          <= op_nxt ? '0 : dec_nxt;
                        flags[idx_nxt] <= op_nxt;
                        state          <= DRIVE;
                        busy           <= 1'b1;
                    end
                end
                DRIVE: begin
                    ack   <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    state <= ACK;
                end
                ACK: begin
                    ptr   <= (winner == PW'(NREQ-1)) ? '0 : winner + 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && found)
            winner <= win_nxt;
    end

endmodule
